rns_fwd_conv: RTL and testbench



---
 rtl/rns_fwd_conv_if.sv | 19 +
 rtl/rns_fwd_conv.sv | 124 ++++++++++++
 tb/tb_rns_fwd_conv.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rns_fwd_conv_if.sv
// rns_fwd_conv_if: sample-in / residues-out handshake bundle for the forward RNS converter
interface rns_fwd_conv_if #(parameter int N = 5);
  logic           in_valid;
  logic           in_ready;
  logic [3*N-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   res_m1;
  logic [N-1:0]   res_m0;
  logic [N:0]     res_p1;
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, res_m1, res_m0, res_p1
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, res_m1, res_m0, res_p1
  );
endinterface

// File: rtl/rns_fwd_conv.sv
// rns_fwd_conv: iterative binary-to-RNS {2^N-1, 2^N, 2^N+1} converter; RNS_FWD_SIGNED_EN selects two's complement input
module rns_fwd_conv #(
  parameter int N = 5
) (
  input  logic          clk,
  input  logic          reset,
  rns_fwd_conv_if.slave bus
);
  localparam int W = 3 * N;
  localparam logic [N-1:0] M1 = {N{1'b1}};
  localparam logic signed [N+2:0] MP = (N+3)'((1 << N) + 1);
  typedef enum logic [1:0] {IDLE, ACC, FIX, DONE} state_t;
  state_t               state_q, state_d;
  logic [1:0]           k_q, k_d;
  logic [W-1:0]         data_q, data_d;
  logic [N-1:0]         acc_m_q, acc_m_d;
  logic signed [N+2:0]  acc_p_q, acc_p_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [N-1:0]         res_m1_q, res_m1_d;
  logic [N-1:0]         res_m0_q, res_m0_d;
  logic [N:0]           res_p1_q, res_p1_d;
  logic [N-1:0]         chunk;
  logic [N:0]           sum_m;
  logic [N-1:0]         acc_m_nx;
  logic signed [N+2:0]  chunk_p;
  logic signed [N+2:0]  acc_p_nx;
  logic [N-1:0]         fix_m;
  logic [N:0]           fix_p;
  logic [N-1:0]         res_m1_nx;
  logic [N:0]           res_p1_nx;
  // Per-chunk accumulation, final range correction and the FSM next state
  always_comb begin
    chunk = k_q == 2'd0 ? data_q[N-1:0] : k_q == 2'd1 ? data_q[2*N-1:N] : data_q[W-1:2*N];
    sum_m = {1'b0, acc_m_q} + {1'b0, chunk};
    acc_m_nx = sum_m[N-1:0] + N'(sum_m[N]);
    chunk_p = {3'b000, chunk};
    acc_p_nx = k_q == 2'd1 ? acc_p_q - chunk_p : acc_p_q + chunk_p;
    fix_m = acc_m_q == M1 ? '0 : acc_m_q;
    fix_p = (N+1)'(acc_p_q[N+2] ? acc_p_q + MP : (acc_p_q >= MP ? acc_p_q - MP : acc_p_q));
`ifdef RNS_FWD_SIGNED_EN
    res_m1_nx = data_q[W-1] ? (fix_m == '0 ? M1 - N'(1) : fix_m - N'(1)) : fix_m;
    res_p1_nx = data_q[W-1] ? (fix_p == (N+1)'(1 << N) ? '0 : fix_p + (N+1)'(1)) : fix_p;
`else
    res_m1_nx = fix_m;
    res_p1_nx = fix_p;
`endif
    state_d = state_q;
    k_d = k_q;
    data_d = data_q;
    acc_m_d = acc_m_q;
    acc_p_d = acc_p_q;
    in_ready_d = in_ready_q;
    out_valid_d = out_valid_q;
    res_m1_d = res_m1_q;
    res_m0_d = res_m0_q;
    res_p1_d = res_p1_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_ready_q && bus.in_valid) begin
          data_d = bus.in_data;
          acc_m_d = '0;
          acc_p_d = '0;
          k_d = 2'd0;
          in_ready_d = 1'b0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_m_d = acc_m_nx;
        acc_p_d = acc_p_nx;
        k_d = k_q + 2'd1;
        state_d = k_q == 2'd2 ? FIX : ACC;
      end
      FIX: begin
        res_m1_d = res_m1_nx;
        res_m0_d = data_q[N-1:0];
        res_p1_d = res_p1_nx;
        out_valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and registered outputs; reset drops any in-flight sample
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      data_q <= '0;
      acc_m_q <= '0;
      acc_p_q <= '0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      res_m1_q <= '0;
      res_m0_q <= '0;
      res_p1_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      data_q <= data_d;
      acc_m_q <= acc_m_d;
      acc_p_q <= acc_p_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_m1_q <= res_m1_d;
      res_m0_q <= res_m0_d;
      res_p1_q <= res_p1_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.res_m1 = res_m1_q;
  assign bus.res_m0 = res_m0_q;
  assign bus.res_p1 = res_p1_q;
endmodule

// File: tb/tb_rns_fwd_conv.sv
// tb_rns_fwd_conv: scoreboard bench for rns_fwd_conv against a plain modular-arithmetic model
module tb_rns_fwd_conv;
  localparam int N = 5;
  localparam int W = 3 * N;
  localparam longint M1 = (1 << N) - 1;
  localparam longint M0 = 1 << N;
  localparam longint P1 = (1 << N) + 1;
  typedef struct {
    logic [N-1:0] m1;
    logic [N-1:0] m0;
    logic [N:0]   p1;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int or_mode = 1;
  bit seen = 0;
  exp_t sb[$];
  int acc_cyc[$];
  rns_fwd_conv_if #(.N(N)) bus();
  rns_fwd_conv #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    bus.out_ready = or_mode == 2 ? 1'($urandom) : (or_mode == 1);
  end
  function automatic exp_t model(logic [W-1:0] x);
    longint v;
    exp_t e;
`ifdef RNS_FWD_SIGNED_EN
    v = longint'($signed(x));
`else
    v = longint'(x);
`endif
    e.m1 = N'(((v % M1) + M1) % M1);
    e.m0 = N'(((v % M0) + M0) % M0);
    e.p1 = (N+1)'(((v % P1) + P1) % P1);
    return e;
  endfunction
  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic send(logic [W-1:0] x, bit track);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = x;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", n, 0);
    else if (track) begin
      sb.push_back(model(x));
      acc_cyc.push_back(cyc + 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data = W'($urandom);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (sb.size() == 0) check("spurious_out_valid", bus.out_valid, 0);
      else begin
        if (!seen) begin
          seen = 1;
          check("latency", cyc - acc_cyc[0], 4);
        end
        check("res_m1", bus.res_m1, sb[0].m1);
        check("res_m0", bus.res_m0, sb[0].m0);
        check("res_p1", bus.res_p1, sb[0].p1);
        if (bus.out_ready) begin
          void'(sb.pop_front());
          void'(acc_cyc.pop_front());
          seen = 0;
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] dir[7];
    dir = '{15'd0, 15'd1000, 15'd992, 15'd31, 15'd32767, 15'h4000, 15'd1023};
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_res_m1", bus.res_m1, 0);
    check("rst_res_m0", bus.res_m0, 0);
    check("rst_res_p1", bus.res_p1, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    foreach (dir[i]) send(dir[i], 1);
    drain();
    or_mode = 0;
    send(15'd12345, 1);
    bus.in_valid = 1'b1;
    bus.in_data = 15'd777;
    repeat (15) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
    end
    check("bp_out_valid", bus.out_valid, 1);
    or_mode = 1;
    send(15'd777, 1);
    drain();
    send(15'd5000, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_res_m1", bus.res_m1, 0);
    check("midrst_res_m0", bus.res_m0, 0);
    check("midrst_res_p1", bus.res_p1, 0);
    send(15'd6000, 1);
    drain();
    or_mode = 2;
    for (int i = 0; i < 60; i++) begin
      send(W'($urandom), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    or_mode = 1;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
